mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the 5-stage MIPS pipeline, directly upstream of the write-back stage. It takes EX/MEM fields
//  and drives the data-RAM request/ack handshake, stalling the pipeline while an access is outstanding.
//  It detects misaligned loads and stores, latches read data, and holds the MEM/WB pipeline register
//  whose outputs feed write-back unchanged (sel and sign-ext stay raw; write-back does lane extraction).
// PARAMETERS
//  DATA_W      32  datapath / RAM word width
//  ADDR_W      32  byte address width
//  REG_ADDR_W  5   GPR index width
//  CP0_ADDR_W  8   CP0 register select width
// PORTS
//  clk                   in   1           pipeline clock
//  rst                   in   1           asynchronous, active-high reset
//  flush                 in   1           exception flush; squashes the current instruction
//  ex_valid              in   1           EX/MEM holds a real instruction
//  mem_read_flag_in      in   1           load
//  mem_write_flag_in     in   1           store
//  mem_sign_ext_flag_in  in   1           sign-extend load
//  mem_sel_in            in   4           size: 0001 byte, 0011 half, 1111 word (unshifted)
//  mem_write_data_in     in   DATA_W      store data (low-aligned)
//  result_in             in   DATA_W      ALU result; byte address for loads/stores
//  write_reg_en_in, write_reg_addr_in, hilo_write_en_in, hi_in, lo_in, cp0_write_en_in, cp0_addr_in,
//  cp0_write_data_in, debug_pc_addr_in   in   as named   passthrough fields
//  ram_en                out  1           RAM request valid
//  ram_write_en          out  4           byte strobes, 0 for loads
//  ram_addr              out  ADDR_W      word address {addr[31:2],2'b00}
//  ram_write_data        out  DATA_W      lane-replicated store data
//  ram_rdata             in   DATA_W      RAM read word, valid with ram_ack
//  ram_ack               in   1           request completes this cycle
//  stall_req             out  1           hold IF..EX this cycle
//  adel, ades            out  1           misaligned load / store (combinational)
//  bad_vaddr             out  ADDR_W      faulting address (result_in)
//  ram_read_data         out  DATA_W      latched read word to write-back
//  mem_read_flag, mem_write_flag, mem_sign_ext_flag, mem_sel, result_out, write_reg_en_out, ...,
//  debug_pc_addr_out     out  as inputs   registered MEM/WB fields
// BEHAVIOUR
//  - Reset: every registered output = 0; FSM = IDLE. ram_en, stall_req, adel, ades = 0 while rst.
//  - mem_op = ex_valid & (rd|wr) & !flush & aligned. Aligned: byte always; half addr[0]==0; word addr[1:0]==0.
//  - Misaligned: adel = rd, ades = wr, bad_vaddr = addr; no RAM request; the instruction advances with
//    write_reg_en cleared. Illegal mem_sel values are handled as word.
//  - Strobes: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111. Data: byte {4{d[7:0]}}, half {2{d[15:0]}}.
//  - FSM IDLE: ram_en = mem_op. On ram_ack in the same cycle, load MEM/WB and stay IDLE (zero stall).
//    Otherwise go to WAIT.
//  - FSM WAIT: ram_en = 1, with request fields held by the stalled EX/MEM inputs. On ram_ack, load MEM/WB
//    and go to IDLE.
//  - stall_req = mem_op & !ram_ack in IDLE/WAIT; = !ram_ack in DRAIN.
//  - While stall_req = 1, MEM/WB loads a bubble (all fields 0) so write-back never repeats a write.
//  - Non-memory instruction: MEM/WB loads on the next edge (1-cycle latency), with no RAM activity.
//  - Flush in IDLE: MEM/WB loads a bubble.
//  - Flush in WAIT (request in flight): go to DRAIN. DRAIN: ram_en = 0, wait for ram_ack, discard the data,
//    load a bubble, go to IDLE. A store already issued is allowed to complete.
//  - ram_read_data latches ram_rdata on the ack cycle of a load; otherwise it holds.
//  - Async rst mid-WAIT/DRAIN: return to IDLE immediately. The RAM side is reset by the same rst.
// STRUCTURE
//  - Shared package/defines: bus widths, mem_sel size encodings, FSM state encoding (IDLE/WAIT/DRAIN).
//  - One sub-module, mem_req_align: combinational alignment check, strobe generation and data replication.
//  - FSM and MEM/WB register live in the top module.
// TESTING
//  1. LW addr 0x1000, ram_ack same cycle, ram_rdata=0xDEADBEEF -> ram_write_en=0000, no stall,
//     next cycle ram_read_data=0xDEADBEEF, mem_sel=1111.
//  2. SB addr 0x1003, data 0x000000A5 -> ram_write_en=1000, ram_write_data=0xA5A5A5A5, ram_addr=0x1000.
//  3. LH addr 0x2001 -> adel=1, bad_vaddr=0x2001, ram_en=0, next cycle write_reg_en_out=0.
//  4. LW, ack delayed 3 cycles -> stall_req=1 for 3 cycles, 3 bubbles into MEM/WB, load written once on ack edge.
//  5. SW in WAIT, flush asserted, ack 2 cycles later -> DRAIN, ram_en=0, stall held until ack, bubble only.
//  6. rst pulse during WAIT -> FSM IDLE, all outputs 0 within the reset cycle; the next LW behaves as in case 1.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared widths, size encodings, FSM states and MEM/WB record
package mem_access_stage_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CP0_ADDR_W = 8;

    localparam logic [3:0] SEL_BYTE = 4'b0001;
    localparam logic [3:0] SEL_HALF = 4'b0011;
    localparam logic [3:0] SEL_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic                  mem_read;
        logic                  mem_write;
        logic                  sign_ext;
        logic [3:0]            sel;
        logic [DATA_W-1:0]     result;
        logic                  wr_en;
        logic [REG_ADDR_W-1:0] wr_addr;
        logic                  hilo_we;
        logic [DATA_W-1:0]     hi;
        logic [DATA_W-1:0]     lo;
        logic                  cp0_we;
        logic [CP0_ADDR_W-1:0] cp0_addr;
        logic [DATA_W-1:0]     cp0_wdata;
        logic [ADDR_W-1:0]     pc;
    } memwb_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-RAM request/ack handshake between MEM stage and RAM
interface mem_access_stage_if;
    import mem_access_stage_pkg::*;

    logic              ram_en;
    logic [3:0]        ram_write_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_write_data;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ack;

    modport master (
        output ram_en, ram_write_en, ram_addr, ram_write_data,
        input  ram_rdata, ram_ack
    );

    modport slave (
        input  ram_en, ram_write_en, ram_addr, ram_write_data,
        output ram_rdata, ram_ack
    );

endinterface

// File: rtl/mem_access_stage_align.sv
// rtl/mem_access_stage_align.sv - alignment check, byte strobes and lane replication for one access
module mem_req_align
    import mem_access_stage_pkg::*;
(
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [3:0]        sel_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              wr_i,
    output logic              aligned_o,
    output logic [3:0]        strobe_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [ADDR_W-1:0] word_addr_o
);

    // Unknown size encodings fall into the word arm.
    always_comb begin
        aligned_o = 1'b1;
        strobe_o  = SEL_WORD;
        wdata_o   = wdata_i;
        case (sel_i)
            SEL_BYTE: begin
                strobe_o = SEL_BYTE << addr_i[1:0];
                wdata_o  = {4{wdata_i[7:0]}};
            end
            SEL_HALF: begin
                aligned_o = ~addr_i[0];
                strobe_o  = SEL_HALF << addr_i[1:0];
                wdata_o   = {2{wdata_i[15:0]}};
            end
            default: aligned_o = (addr_i[1:0] == 2'b00);
        endcase
        if (!wr_i) begin
            strobe_o = 4'b0000;
        end
    end

    assign word_addr_o = {addr_i[ADDR_W-1:2], 2'b00};

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: RAM handshake FSM, misalignment detect, MEM/WB register
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  ex_valid,
    input  logic                  mem_read_flag_in,
    input  logic                  mem_write_flag_in,
    input  logic                  mem_sign_ext_flag_in,
    input  logic [3:0]            mem_sel_in,
    input  logic [DATA_W-1:0]     mem_write_data_in,
    input  logic [DATA_W-1:0]     result_in,
    input  logic                  write_reg_en_in,
    input  logic [REG_ADDR_W-1:0] write_reg_addr_in,
    input  logic                  hilo_write_en_in,
    input  logic [DATA_W-1:0]     hi_in,
    input  logic [DATA_W-1:0]     lo_in,
    input  logic                  cp0_write_en_in,
    input  logic [CP0_ADDR_W-1:0] cp0_addr_in,
    input  logic [DATA_W-1:0]     cp0_write_data_in,
    input  logic [ADDR_W-1:0]     debug_pc_addr_in,
    mem_access_stage_if.master    ram,
    output logic                  stall_req,
    output logic                  adel,
    output logic                  ades,
    output logic [ADDR_W-1:0]     bad_vaddr,
    output logic [DATA_W-1:0]     ram_read_data,
    output logic                  mem_read_flag,
    output logic                  mem_write_flag,
    output logic                  mem_sign_ext_flag,
    output logic [3:0]            mem_sel,
    output logic [DATA_W-1:0]     result_out,
    output logic                  write_reg_en_out,
    output logic [REG_ADDR_W-1:0] write_reg_addr_out,
    output logic                  hilo_write_en_out,
    output logic [DATA_W-1:0]     hi_out,
    output logic [DATA_W-1:0]     lo_out,
    output logic                  cp0_write_en_out,
    output logic [CP0_ADDR_W-1:0] cp0_addr_out,
    output logic [DATA_W-1:0]     cp0_write_data_out,
    output logic [ADDR_W-1:0]     debug_pc_addr_out
);

    state_e            state_q, state_d;
    memwb_t            memwb_q, memwb_d, incoming;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              aligned, is_mem, mem_op, misaligned, req_en;
    logic [3:0]        strobe;
    logic [DATA_W-1:0] rep_data;
    logic [ADDR_W-1:0] word_addr;

    mem_req_align u_align (
        .addr_i      (result_in),
        .sel_i       (mem_sel_in),
        .wdata_i     (mem_write_data_in),
        .wr_i        (mem_write_flag_in),
        .aligned_o   (aligned),
        .strobe_o    (strobe),
        .wdata_o     (rep_data),
        .word_addr_o (word_addr)
    );

    assign is_mem     = ex_valid & (mem_read_flag_in | mem_write_flag_in);
    assign mem_op     = is_mem & aligned & ~flush & ~rst;
    assign misaligned = is_mem & ~aligned & ~flush & ~rst & (state_q != ST_DRAIN);

    assign incoming = '{
        mem_read:  mem_read_flag_in,
        mem_write: mem_write_flag_in,
        sign_ext:  mem_sign_ext_flag_in,
        sel:       mem_sel_in,
        result:    result_in,
        wr_en:     write_reg_en_in & ~(is_mem & ~aligned),
        wr_addr:   write_reg_addr_in,
        hilo_we:   hilo_write_en_in,
        hi:        hi_in,
        lo:        lo_in,
        cp0_we:    cp0_write_en_in,
        cp0_addr:  cp0_addr_in,
        cp0_wdata: cp0_write_data_in,
        pc:        debug_pc_addr_in
    };

    // MEM/WB defaults to a bubble; only a retiring instruction overrides it.
    always_comb begin
        state_d   = state_q;
        memwb_d   = '0;
        rdata_d   = rdata_q;
        req_en    = 1'b0;
        stall_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_en    = mem_op;
                stall_req = mem_op & ~ram.ram_ack;
                if (mem_op && !ram.ram_ack) begin
                    state_d = ST_WAIT;
                end else if (ex_valid && !flush) begin
                    memwb_d = incoming;
                    if (mem_op && mem_read_flag_in) begin
                        rdata_d = ram.ram_rdata;
                    end
                end
            end
            ST_WAIT: begin
                req_en    = 1'b1;
                stall_req = ~ram.ram_ack;
                if (ram.ram_ack) begin
                    state_d = ST_IDLE;
                    if (!flush) begin
                        memwb_d = incoming;
                        if (mem_read_flag_in) begin
                            rdata_d = ram.ram_rdata;
                        end
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                stall_req = ~ram.ram_ack;
                if (ram.ram_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            memwb_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            memwb_q <= memwb_d;
            rdata_q <= rdata_d;
        end
    end

    assign ram.ram_en         = req_en;
    assign ram.ram_write_en   = req_en ? strobe : 4'b0000;
    assign ram.ram_addr       = req_en ? word_addr : '0;
    assign ram.ram_write_data = req_en ? rep_data : '0;

    assign adel      = misaligned & mem_read_flag_in;
    assign ades      = misaligned & mem_write_flag_in;
    assign bad_vaddr = misaligned ? result_in : '0;

    assign ram_read_data      = rdata_q;
    assign mem_read_flag      = memwb_q.mem_read;
    assign mem_write_flag     = memwb_q.mem_write;
    assign mem_sign_ext_flag  = memwb_q.sign_ext;
    assign mem_sel            = memwb_q.sel;
    assign result_out         = memwb_q.result;
    assign write_reg_en_out   = memwb_q.wr_en;
    assign write_reg_addr_out = memwb_q.wr_addr;
    assign hilo_write_en_out  = memwb_q.hilo_we;
    assign hi_out             = memwb_q.hi;
    assign lo_out             = memwb_q.lo;
    assign cp0_write_en_out   = memwb_q.cp0_we;
    assign cp0_addr_out       = memwb_q.cp0_addr;
    assign cp0_write_data_out = memwb_q.cp0_wdata;
    assign debug_pc_addr_out  = memwb_q.pc;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, ex_valid = 1'b0;
    logic        rd_i = 1'b0, wr_i = 1'b0, sx_i = 1'b0, wre_i = 1'b0;
    logic        hilo_we_i = 1'b0, cp0_we_i = 1'b0;
    logic [3:0]  sel_i = 4'h0;
    logic [4:0]  waddr_i = 5'h0;
    logic [7:0]  cp0_addr_i = 8'h0;
    logic [31:0] wdata_i = 0, addr_i = 0, hi_i = 0, lo_i = 0, cp0_wdata_i = 0, pc_i = 0;

    logic        stall, adel, ades, o_rd, o_wr, o_sx, o_wre, o_hilo_we, o_cp0_we;
    logic [3:0]  o_sel;
    logic [4:0]  o_waddr;
    logic [7:0]  o_cp0_addr;
    logic [31:0] bad_vaddr, o_rdata, o_result, o_hi, o_lo, o_cp0_wdata, o_pc;

    int nchk = 0, nerr = 0;

    mem_access_stage_if ram_bus ();

    mem_access_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid),
        .mem_read_flag_in(rd_i), .mem_write_flag_in(wr_i), .mem_sign_ext_flag_in(sx_i),
        .mem_sel_in(sel_i), .mem_write_data_in(wdata_i), .result_in(addr_i),
        .write_reg_en_in(wre_i), .write_reg_addr_in(waddr_i), .hilo_write_en_in(hilo_we_i),
        .hi_in(hi_i), .lo_in(lo_i), .cp0_write_en_in(cp0_we_i), .cp0_addr_in(cp0_addr_i),
        .cp0_write_data_in(cp0_wdata_i), .debug_pc_addr_in(pc_i),
        .ram(ram_bus.master),
        .stall_req(stall), .adel(adel), .ades(ades), .bad_vaddr(bad_vaddr),
        .ram_read_data(o_rdata), .mem_read_flag(o_rd), .mem_write_flag(o_wr),
        .mem_sign_ext_flag(o_sx), .mem_sel(o_sel), .result_out(o_result),
        .write_reg_en_out(o_wre), .write_reg_addr_out(o_waddr), .hilo_write_en_out(o_hilo_we),
        .hi_out(o_hi), .lo_out(o_lo), .cp0_write_en_out(o_cp0_we), .cp0_addr_out(o_cp0_addr),
        .cp0_write_data_out(o_cp0_wdata), .debug_pc_addr_out(o_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a request is either free, outstanding, or outstanding-but-squashed.
    logic [182:0] exp_wb = '0, n_wb = '0, in_wb, dut_wb;
    logic [31:0]  exp_rdata = '0, n_rdata = '0;
    bit           busy = 0, squashed = 0, n_busy = 0, n_squashed = 0;

    assign dut_wb = {o_rd, o_wr, o_sx, o_sel, o_result, o_wre, o_waddr, o_hilo_we,
                     o_hi, o_lo, o_cp0_we, o_cp0_addr, o_cp0_wdata, o_pc};

    always begin : compare
        bit          is_mem, misal, req, en, e_stall, e_adel, e_ades, ack;
        int unsigned size, off;
        logic [3:0]  mask;
        logic [31:0] rep;
        @(negedge clk);
        ack = ram_bus.ram_ack;
        if (rst) begin
            exp_wb = '0; exp_rdata = '0; busy = 0; squashed = 0;
        end
        size   = (sel_i == 4'b0001) ? 1 : (sel_i == 4'b0011) ? 2 : 4;
        off    = addr_i % 4;
        is_mem = ex_valid && (rd_i || wr_i);
        misal  = (addr_i % size) != 0;
        req    = !rst && !busy && !squashed && is_mem && !misal && !flush;
        en = 0; e_stall = 0; e_adel = 0; e_ades = 0;
        if (!rst) begin
            if (squashed) e_stall = !ack;
            else if (busy) begin en = 1; e_stall = !ack; end
            else begin
                en = req; e_stall = req && !ack;
                e_adel = is_mem && misal && !flush && rd_i;
                e_ades = is_mem && misal && !flush && wr_i;
            end
        end
        mask = 4'b0000;
        for (int k = 0; k < int'(size); k++) if (off + k < 4) mask[off+k] = wr_i;
        for (int j = 0; j < 4; j++) rep[8*j +: 8] = wdata_i[8*(j % int'(size)) +: 8];
        chk("ram_en", ram_bus.ram_en, en);
        chk("ram_write_en", ram_bus.ram_write_en, en ? mask : 4'b0000);
        chk("ram_addr", ram_bus.ram_addr, en ? addr_i - off : 32'h0);
        chk("ram_write_data", ram_bus.ram_write_data, en ? rep : 32'h0);
        chk("stall_req", stall, e_stall);
        chk("adel", adel, e_adel);
        chk("ades", ades, e_ades);
        chk("bad_vaddr", bad_vaddr, (e_adel || e_ades) ? addr_i : 32'h0);
        chk("memwb", dut_wb, exp_wb);
        chk("ram_read_data", o_rdata, exp_rdata);

        in_wb = {rd_i, wr_i, sx_i, sel_i, addr_i, wre_i & !(is_mem && misal), waddr_i,
                 hilo_we_i, hi_i, lo_i, cp0_we_i, cp0_addr_i, cp0_wdata_i, pc_i};
        n_wb = '0; n_rdata = exp_rdata; n_busy = busy; n_squashed = squashed;
        if (rst) begin
            n_busy = 0; n_squashed = 0;
        end else if (squashed) begin
            if (ack) n_squashed = 0;
        end else if (busy) begin
            if (ack) begin
                n_busy = 0;
                if (!flush) begin n_wb = in_wb; if (rd_i) n_rdata = ram_bus.ram_rdata; end
            end else if (flush) begin
                n_busy = 0; n_squashed = 1;
            end
        end else if (req && !ack) begin
            n_busy = 1;
        end else if (ex_valid && !flush) begin
            n_wb = in_wb;
            if (req && rd_i) n_rdata = ram_bus.ram_rdata;
        end
        @(posedge clk);
        exp_wb = n_wb; exp_rdata = n_rdata; busy = n_busy; squashed = n_squashed;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input bit v, input bit rd, input bit wr, input bit sx,
                         input logic [3:0] sel, input logic [31:0] addr,
                         input logic [31:0] wd, input bit wre);
        ex_valid = v; rd_i = rd; wr_i = wr; sx_i = sx; sel_i = sel;
        addr_i = addr; wdata_i = wd; wre_i = wre;
        pc_i = pc_i + 32'd4;
        waddr_i = pc_i[6:2]; hi_i = ~addr; lo_i = wd ^ 32'h5A5A5A5A;
        hilo_we_i = sel[1]; cp0_we_i = sel[2]; cp0_addr_i = pc_i[9:2]; cp0_wdata_i = addr + wd;
    endtask

    task automatic ram(input bit ack, input logic [31:0] rdata);
        ram_bus.ram_ack = ack;
        ram_bus.ram_rdata = rdata;
    endtask

    task automatic idle;
        instr(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        ram(0, 32'h0);
    endtask

    initial begin : stim
        int scnt;
        ram(0, 32'h0);
        #6;
        chk("rst_ram_en", ram_bus.ram_en, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_result", o_result, 32'h0);
        chk("rst_rdata", o_rdata, 32'h0);
        tick; tick; rst = 1'b0; idle;

        tick; instr(1, 1, 0, 0, 4'hF, 32'h1000, 32'h0, 1); ram(1, 32'hDEADBEEF); #5;
        chk("t1_en", ram_bus.ram_en, 1'b1);
        chk("t1_wen", ram_bus.ram_write_en, 4'b0000);
        chk("t1_stall", stall, 1'b0);
        tick; idle; #5;
        chk("t1_rdata", o_rdata, 32'hDEADBEEF);
        chk("t1_sel", o_sel, 4'hF);

        tick; instr(1, 0, 1, 0, 4'h1, 32'h1003, 32'h000000A5, 0); ram(1, 32'h0); #5;
        chk("t2_wen", ram_bus.ram_write_en, 4'b1000);
        chk("t2_wdata", ram_bus.ram_write_data, 32'hA5A5A5A5);
        chk("t2_addr", ram_bus.ram_addr, 32'h1000);
        tick; instr(1, 0, 1, 0, 4'h3, 32'h2002, 32'h00001234, 0); ram(1, 32'h0); #5;
        chk("sh_wen", ram_bus.ram_write_en, 4'b1100);
        chk("sh_wdata", ram_bus.ram_write_data, 32'h12341234);
        tick; instr(1, 0, 0, 0, 4'h0, 32'h55, 32'h0, 1); ram(0, 32'h0); #5;
        chk("alu_en", ram_bus.ram_en, 1'b0);
        tick; idle; #5;
        chk("alu_result", o_result, 32'h55);
        chk("alu_wre", o_wre, 1'b1);

        tick; instr(1, 1, 0, 1, 4'h3, 32'h2001, 32'h0, 1); #5;
        chk("t3_adel", adel, 1'b1);
        chk("t3_bad_vaddr", bad_vaddr, 32'h2001);
        chk("t3_en", ram_bus.ram_en, 1'b0);
        tick; instr(1, 0, 1, 0, 4'hF, 32'h3002, 32'h77, 0); #5;
        chk("sw_ades", ades, 1'b1);
        chk("t3_wre", o_wre, 1'b0);
        chk("t3_result", o_result, 32'h2001);

        tick; idle;
        tick; instr(1, 1, 0, 0, 4'hF, 32'h4000, 32'h0, 1); ram(0, 32'h0);
        scnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick;
            if (i == 3) ram(1, 32'h12345678);
            #5;
            if (stall) scnt++;
        end
        chk("t4_stall_cycles", scnt, 3);
        tick; idle; #5;
        chk("t4_rdata", o_rdata, 32'h12345678);
        chk("t4_wre", o_wre, 1'b1);
        tick; #5;
        chk("t4_once", o_wre, 1'b0);

        tick; instr(1, 0, 1, 0, 4'hF, 32'h5000, 32'hCAFEF00D, 0); ram(0, 32'h0);
        tick; flush = 1'b1; #5;
        chk("t5_wait_en", ram_bus.ram_en, 1'b1);
        chk("t5_wait_stall", stall, 1'b1);
        tick; flush = 1'b0; idle; #5;
        chk("t5_drain_en", ram_bus.ram_en, 1'b0);
        chk("t5_drain_stall", stall, 1'b1);
        tick; ram(1, 32'h0); #5;
        chk("t5_ack_stall", stall, 1'b0);
        tick; idle; #5;
        chk("t5_bubble_wre", o_wre, 1'b0);
        chk("t5_bubble_wr", o_wr, 1'b0);

        tick; instr(1, 1, 0, 0, 4'hF, 32'h6000, 32'h0, 1); ram(0, 32'h0);
        tick; #2; rst = 1'b1; #4;
        chk("t6_en", ram_bus.ram_en, 1'b0);
        chk("t6_stall", stall, 1'b0);
        chk("t6_result", o_result, 32'h0);
        chk("t6_rdata_rst", o_rdata, 32'h0);
        tick; rst = 1'b0; instr(1, 1, 0, 0, 4'hF, 32'h7000, 32'h0, 1); ram(1, 32'h0BADF00D); #5;
        chk("t6_lw_en", ram_bus.ram_en, 1'b1);
        chk("t6_lw_stall", stall, 1'b0);
        tick; idle; #5;
        chk("t6_lw_rdata", o_rdata, 32'h0BADF00D);
        tick; tick;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
